// File: rtl/sram_axi_pkg.sv
// Shared types and constants for the SRAM-style to AXI bridge.
// Covers FSM states, fixed AXI IDs, burst type and transfer-size codes.
package sram_axi_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   localparam int unsigned INST_ID = 0;
   localparam int unsigned DATA_ID = 1;

   localparam logic [1:0] BURST_INCR = 2'b01;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP
   } state_t;

endpackage

// File: rtl/arb2_rr.sv
// Two-input round-robin arbiter. Grants are combinational.
// A registered last-grant flag is cleared to port 0 on reset, so port 1 wins the first tie.
module arb2_rr (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0_c,
   output logic gnt1_c
);

   logic last1_q;

   // On a tie, the port that was not granted last wins.
   assign gnt1_c = req1 & (~req0 | ~last1_q);
   assign gnt0_c = req0 & ~gnt1_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         last1_q <= 1'b0;
      end else if (gnt0_c | gnt1_c) begin
         last1_q <= gnt1_c;
      end
   end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Bridges the instruction and data SRAM-style ports onto one AXI master.
// Only one single-beat AXI transaction is outstanding at any time.
module sram_axi_arbiter
   import sram_axi_pkg::*;
#(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  inst_req,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic                  inst_addr_ok,
   output logic                  inst_data_ok,
   output logic [31:0]           inst_rdata,

   input  logic                  data_req,
   input  logic                  data_wr,
   input  logic [1:0]            data_size,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [3:0]            data_wstrb,
   input  logic [31:0]           data_wdata,
   output logic                  data_addr_ok,
   output logic                  data_data_ok,
   output logic [31:0]           data_rdata,

   output logic [ID_WIDTH-1:0]   arid,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [1:0]            arlock,
   output logic [3:0]            arcache,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,

   input  logic [ID_WIDTH-1:0]   rid,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready,

   output logic [ID_WIDTH-1:0]   awid,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [7:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic [1:0]            awlock,
   output logic [3:0]            awcache,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,

   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,

   input  logic [ID_WIDTH-1:0]   bid,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready
);

   state_t                  state_q, state_d;
   logic                    idle;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [2:0]              size_q;
   logic [3:0]              wstrb_q;
   logic [31:0]             wdata_q;
   logic                    owner_q;
   logic                    aw_done_q;
   logic                    w_done_q;
   logic                    unused_resp;

   assign idle = (state_q == IDLE);

   // Requests only compete while idle, so addr_ok never depends on AXI inputs.
   arb2_rr u_arb (
      .clk    (clk),
      .rst    (rst),
      .req0   (inst_req & idle),
      .req1   (data_req & idle),
      .gnt0_c (inst_addr_ok),
      .gnt1_c (data_addr_ok)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the winning request; owner_q is 1 for the data port.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         size_q    <= '0;
         wstrb_q   <= '0;
         wdata_q   <= '0;
         owner_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else if (data_addr_ok) begin
         addr_q    <= data_addr;
         size_q    <= {1'b0, data_size};
         wstrb_q   <= data_wstrb;
         wdata_q   <= data_wdata;
         owner_q   <= 1'b1;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else if (inst_addr_ok) begin
         addr_q    <= inst_addr;
         size_q    <= SIZE_WORD;
         wstrb_q   <= '0;
         wdata_q   <= '0;
         owner_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else if (state_q == WR_REQ) begin
         if (awvalid && awready) aw_done_q <= 1'b1;
         if (wvalid && wready)   w_done_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      arvalid      = 1'b0;
      rready       = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (data_addr_ok) begin
               state_d = data_wr ? WR_REQ : RD_ADDR;
            end else if (inst_addr_ok) begin
               state_d = RD_ADDR;
            end
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (rvalid) begin
               inst_data_ok = ~owner_q;
               data_data_ok = owner_q;
               state_d      = IDLE;
            end
         end
         WR_REQ: begin
            // Address and data channels complete independently.
            awvalid = ~aw_done_q;
            wvalid  = ~w_done_q;
            if ((aw_done_q | awready) && (w_done_q | wready)) state_d = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               data_data_ok = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign arid    = owner_q ? ID_WIDTH'(DATA_ID) : ID_WIDTH'(INST_ID);
   assign araddr  = addr_q;
   assign arsize  = size_q;
   assign arlen   = 8'd0;
   assign arburst = BURST_INCR;
   assign arlock  = 2'd0;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign awid    = ID_WIDTH'(DATA_ID);
   assign awaddr  = addr_q;
   assign awsize  = size_q;
   assign awlen   = 8'd0;
   assign awburst = BURST_INCR;
   assign awlock  = 2'd0;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;

   assign inst_rdata = rdata;
   assign data_rdata = rdata;

   // Response IDs and status are deliberately ignored.
   assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: a read-vector table plus hand-written
// sequences for arbitration, split write handshakes and mid-transaction reset.
module tb_sram_axi_arbiter;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst, awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   int errors = 0;
   int checks = 0;

   sram_axi_arbiter #(.ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_data;
      logic [31:0] addr;
      logic [1:0]  size;
      int          ar_wait;
      int          r_wait;
      logic [1:0]  resp;
      logic [31:0] rd;
      logic [3:0]  exp_arid;
      logic [2:0]  exp_arsize;
   } rd_vec_t;

   rd_vec_t rv[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Starts and ends just after a falling edge.
   task automatic run_read(input rd_vec_t v);
      data_wr   = 1'b0;
      data_size = v.size;
      data_addr = v.addr;
      inst_addr = v.addr;
      inst_req  = !v.is_data;
      data_req  = v.is_data;
      #1;
      chk("rd_addr_ok_win",  v.is_data ? 32'(data_addr_ok) : 32'(inst_addr_ok), 32'd1);
      chk("rd_addr_ok_lose", v.is_data ? 32'(inst_addr_ok) : 32'(data_addr_ok), 32'd0);
      @(negedge clk);
      inst_req = 1'b0;
      data_req = 1'b0;
      for (int k = 0; k <= v.ar_wait; k++) begin
         arready = (k == v.ar_wait);
         #1;
         chk("rd_arvalid", 32'(arvalid), 32'd1);
         chk("rd_araddr",  araddr, v.addr);
         chk("rd_arsize",  32'(arsize), 32'(v.exp_arsize));
         chk("rd_arid",    32'(arid), 32'(v.exp_arid));
         chk("rd_no_dok",  32'({inst_data_ok, data_data_ok}), 32'd0);
         @(negedge clk);
      end
      arready = 1'b0;
      for (int k = 0; k <= v.r_wait; k++) begin
         rvalid = (k == v.r_wait);
         rdata  = (k == v.r_wait) ? v.rd : 32'h0;
         rresp  = v.resp;
         #1;
         chk("rd_rready",  32'(rready), 32'd1);
         chk("rd_arv_low", 32'(arvalid), 32'd0);
         chk("rd_inst_dok", 32'(inst_data_ok), 32'((k == v.r_wait) && !v.is_data));
         chk("rd_data_dok", 32'(data_data_ok), 32'((k == v.r_wait) && v.is_data));
         if (k == v.r_wait) chk("rd_rdata", v.is_data ? data_rdata : inst_rdata, v.rd);
         @(negedge clk);
      end
      rvalid = 1'b0;
      rresp  = 2'b00;
      #1;
      chk("rd_back_idle", 32'({rready, arvalid, inst_data_ok, data_data_ok}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rv[0] = '{1'b0, 32'hBFC00000, 2'd0, 0, 0, 2'b00, 32'h3C1D0001, 4'd0, 3'd2};
      rv[1] = '{1'b1, 32'h1FE40004, 2'd2, 2, 1, 2'b00, 32'h12345678, 4'd1, 3'd2};
      rv[2] = '{1'b1, 32'h00000003, 2'd0, 0, 0, 2'b10, 32'hDEADBEEF, 4'd1, 3'd0};
      rv[3] = '{1'b0, 32'h00001000, 2'd0, 5, 0, 2'b00, 32'hA5A5A5A5, 4'd0, 3'd2};
      rv[4] = '{1'b1, 32'h00002002, 2'd1, 1, 3, 2'b00, 32'h0000BEEF, 4'd1, 3'd1};

      rst = 1'b1;
      inst_req = 0; inst_addr = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
      arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
      chk("rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
      chk("rst_araddr", araddr, 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      chk("const_len", 32'({arlen, awlen}), 32'd0);
      chk("const_burst", 32'({arburst, awburst}), 32'h5);
      chk("const_wlast", 32'(wlast), 32'd1);
      chk("const_misc", 32'({arlock, arcache, arprot, awlock, awcache, awprot}), 32'd0);

      for (int i = 0; i < 5; i++) run_read(rv[i]);

      // Write with wready arriving three cycles after the address handshake.
      data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h1FE41000;
      data_wstrb = 4'b0001; data_wdata = 32'h41;
      #1;
      chk("wr_addr_ok", 32'(data_addr_ok), 32'd1);
      @(negedge clk);
      data_req = 0; data_wr = 0; awready = 1; wready = 0;
      #1;
      chk("wr_valids", 32'({awvalid, wvalid}), 32'h3);
      chk("wr_awaddr", awaddr, 32'h1FE41000);
      chk("wr_awsize", 32'(awsize), 32'd0);
      chk("wr_awid", 32'(awid), 32'd1);
      chk("wr_wdata", wdata, 32'h41);
      chk("wr_wstrb", 32'(wstrb), 32'h1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         awready = 0;
         wready  = (k == 3);
         #1;
         chk("wr_aw_dropped", 32'(awvalid), 32'd0);
         chk("wr_w_held", 32'(wvalid), 32'd1);
         chk("wr_no_bready", 32'(bready), 32'd0);
      end
      @(negedge clk);
      wready = 0;
      #1;
      chk("wr_resp_state", 32'({bready, awvalid, wvalid}), 32'h4);
      chk("wr_no_dok_yet", 32'(data_data_ok), 32'd0);
      @(negedge clk);
      bvalid = 1;
      #1;
      chk("wr_dok", 32'({data_data_ok, inst_data_ok}), 32'h2);
      @(negedge clk);
      bvalid = 0;
      #1;
      chk("wr_dok_once", 32'({data_data_ok, bready}), 32'd0);

      // Write with both channels accepted together and an error response.
      data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h00000080;
      data_wstrb = 4'hF; data_wdata = 32'hCAFEF00D;
      #1;
      chk("wr2_addr_ok", 32'(data_addr_ok), 32'd1);
      @(negedge clk);
      data_req = 0; data_wr = 0; awready = 1; wready = 1;
      #1;
      chk("wr2_valids", 32'({awvalid, wvalid}), 32'h3);
      chk("wr2_awsize", 32'(awsize), 32'd2);
      chk("wr2_wdata", wdata, 32'hCAFEF00D);
      @(negedge clk);
      awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
      #1;
      chk("wr2_bready", 32'({bready, awvalid, wvalid}), 32'h4);
      chk("wr2_dok", 32'(data_data_ok), 32'd1);
      @(negedge clk);
      bvalid = 0; bresp = 0;
      #1;
      chk("wr2_idle", 32'({data_data_ok, bready}), 32'd0);

      // Tie after reset: data first, then inst while data keeps requesting.
      rst = 1;
      @(negedge clk);
      rst = 0;
      inst_req = 1; inst_addr = 32'h200;
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h100;
      #1;
      chk("arb_tie1_data", 32'(data_addr_ok), 32'd1);
      chk("arb_tie1_inst", 32'(inst_addr_ok), 32'd0);
      @(negedge clk);
      data_req = 0; arready = 1;
      #1;
      chk("arb_busy_inst", 32'(inst_addr_ok), 32'd0);
      chk("arb_d_arid", 32'(arid), 32'd1);
      chk("arb_d_araddr", araddr, 32'h100);
      @(negedge clk);
      arready = 0; rvalid = 1; rdata = 32'h11;
      #1;
      chk("arb_d_dok", 32'({inst_data_ok, data_data_ok}), 32'h1);
      chk("arb_d_rdata", data_rdata, 32'h11);
      @(negedge clk);
      rvalid = 0; data_req = 1;
      #1;
      chk("arb_tie2_inst", 32'(inst_addr_ok), 32'd1);
      chk("arb_tie2_data", 32'(data_addr_ok), 32'd0);
      @(negedge clk);
      inst_req = 0; data_req = 0; arready = 1;
      #1;
      chk("arb_i_arid", 32'(arid), 32'd0);
      chk("arb_i_araddr", araddr, 32'h200);
      @(negedge clk);
      arready = 0; rvalid = 1; rdata = 32'h22;
      #1;
      chk("arb_i_dok", 32'({inst_data_ok, data_data_ok}), 32'h2);
      @(negedge clk);
      rvalid = 0;

      // Reset while waiting for read data abandons the read.
      inst_req = 1; inst_addr = 32'h300;
      #1;
      chk("rr_addr_ok", 32'(inst_addr_ok), 32'd1);
      @(negedge clk);
      inst_req = 0; arready = 1;
      @(negedge clk);
      arready = 0;
      #1;
      chk("rr_rready", 32'(rready), 32'd1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      chk("rr_after_rst", 32'({rready, arvalid, inst_data_ok, data_data_ok}), 32'd0);
      @(negedge clk);
      #1;
      chk("rr_no_late_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      run_read(rv[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
